branch_resolve_unit: RTL
========================

Name: branch_resolve_unit

Overview:
EX-stage partner of the (2,1) correlating branch predictor. It queues every prediction issued at fetch, compares the queue head against the branch outcome computed in EX, and drives the predictor's training interface (actual_outcome, branch_EX_done, BHT index). On a misprediction it raises a one-cycle flush and a redirect PC to the fetch unit.

Parameters:
DEPTH, 4, in-flight prediction queue entries (power of 2, 2..16)
IDX_W, 4, BHT index width ({ghr bit, PC[4:2]})

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, synchronous, active-low
pred_valid  in  1  fetch issued a branch prediction this cycle
pred_pc  in  32  PC of the predicted branch
pred_taken  in  1  prediction bit (1 = Taken)
pred_index  in  IDX_W  BHT index used for the prediction
ex_valid  in  1  EX has resolved a branch this cycle
ex_pc  in  32  PC of the resolved branch
ex_taken  in  1  actual condition result
ex_target  in  32  computed taken target
q_full  out  1  queue full; fetch must stall branch issue
upd_valid  out  1  branch_EX_done to predictor
upd_taken  out  1  actual_outcome to predictor
upd_index  out  IDX_W  BHT entry to train
flush  out  1  squash younger instructions
redirect_pc  out  32  fetch restart PC, valid when flush=1
err_orphan  out  1  sticky: resolve with empty queue or PC mismatch

Behaviour:
- Reset (rst_n=0 at clk edge): queue empty, pointers 0, all outputs 0, redirect_pc=0, err_orphan=0. Reset mid-operation discards all in-flight entries.
- Queue: circular FIFO of {pc, taken, index}; wr/rd pointers with an extra wrap bit; q_full = (count==DEPTH), combinational from registered count.
- Enqueue: pred_valid && !q_full writes the tail. pred_valid while full: entry dropped (fetch contract violation, no flag).
- Resolve: ex_valid && !empty pops the head. Outputs registered, latency 1 cycle: upd_valid=1, upd_taken=ex_taken, upd_index=head.index, all for exactly one cycle.
- Mispredict: head.taken != ex_taken -> next cycle flush=1 for one cycle, redirect_pc = ex_taken ? ex_target : ex_pc+4 (32-bit wrap). The same edge empties the queue (all younger entries are wrong-path).
- PC check: head.pc != ex_pc -> err_orphan set, update still issued from the head, and flush forced with the redirect computed from ex_*.
- ex_valid while empty: err_orphan set, no update, no flush.
- Simultaneous enqueue and resolve: both occur; legal when full (count unchanged). Enqueue on the same edge as a mispredict pop is discarded (flush wins). Enqueue on the edge where flush=1 is output is discarded.
- FSM: IDLE (empty), TRACK (count>0), FLUSH (one cycle, flush asserted, enqueue blocked) -> IDLE.

Optional Feature:
BRU_STATS_EN: when defined, adds outputs stat_branches[15:0] and stat_mispredicts[15:0]. stat_branches increments on each upd_valid. stat_mispredicts increments on each flush caused by a mispredict or a PC mismatch. Both saturate at 16'hFFFF and clear on reset. When undefined, the ports and logic are absent.

Decomposition:
- Shared package bp_pkg: IDX_W, the taken/not-taken encoding constants, the queue entry struct {pc, taken, index}, and the FSM state enum.
- One sub-module, bru_pred_fifo: a generic DEPTH-entry queue with push, pop, clear, full and empty, and a head read port.

Test Plan:
1. Reset, then pred_valid pc=0x10 taken=1 idx=4; next cycle ex_valid pc=0x10 taken=1 -> one cycle later upd_valid=1, upd_taken=1, upd_index=4, flush=0.
2. Prediction pc=0x20 taken=1 idx=0, followed by 2 more predictions; resolve pc=0x20 taken=0 -> flush=1 and redirect_pc=0x24 for one cycle; queue empty; q_full=0.
3. Prediction taken=0; resolve taken=1 with ex_target=0x100 -> flush=1, redirect_pc=0x100, upd_taken=1.
4. Push 4 entries -> q_full=1; a 5th pred_valid is dropped; a push and a correct pop on the same edge keep q_full=1 and maintain FIFO order.
5. ex_valid with an empty queue -> err_orphan=1 (sticky), upd_valid=0; rst_n=0 clears it.
6. With BRU_STATS_EN defined: 3 correct and 2 mispredicted resolves -> stat_branches=5, stat_mispredicts=2.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor / branch resolve unit pair:
// BHT index width, outcome encoding, in-flight queue entry and FSM states.
package bp_pkg;

  localparam int unsigned IDX_W = 4;

  localparam logic TAKEN     = 1'b1;
  localparam logic NOT_TAKEN = 1'b0;

  typedef struct packed {
    logic [31:0]      pc;
    logic             taken;
    logic [IDX_W-1:0] index;
  } bru_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRACK,
    ST_FLUSH
  } bru_state_t;

  // Fetch restart address after a resolved branch: target if taken, else fall-through.
  function automatic logic [31:0] bru_redirect(input logic        taken,
                                               input logic [31:0] pc,
                                               input logic [31:0] target);
    return (taken == TAKEN) ? target : pc + 32'd4;
  endfunction

endpackage

// File: rtl/bru_pred_fifo.sv
// Generic DEPTH-entry circular queue with wrap-bit pointers, synchronous
// clear, and a combinational head read port.
module bru_pred_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign count_o = wr_q - rd_q;
  assign full_o  = (count_o == (AW+1)'(DEPTH));
  assign empty_o = (wr_q == rd_q);
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  // A push into a full queue is only accepted when the head leaves on the same edge.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  // Pointer update; clear discards every stored entry.
  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // Entry storage, no reset needed since pointers define validity.
  always_ff @(posedge clk) begin
    if (rst_n && !clear_i && do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolve unit: queues fetch predictions, checks them against
// EX outcomes, trains the predictor and flushes/redirects on mispredict.
// Optional build macro BRU_STATS_EN adds saturating branch/mispredict counters.
// IDX_W must match bp_pkg::IDX_W since the queue entry is sized from the package.
module branch_resolve_unit
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDX_W = bp_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pred_valid,
  input  logic [31:0]      pred_pc,
  input  logic             pred_taken,
  input  logic [IDX_W-1:0] pred_index,
  input  logic             ex_valid,
  input  logic [31:0]      ex_pc,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  output logic             q_full,
  output logic             upd_valid,
  output logic             upd_taken,
  output logic [IDX_W-1:0] upd_index,
  output logic             flush,
  output logic [31:0]      redirect_pc,
  output logic             err_orphan
`ifdef BRU_STATS_EN
  ,
  output logic [15:0]      stat_branches,
  output logic [15:0]      stat_mispredicts
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  bru_entry_t       wr_entry, head;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] count, count_nxt;
  logic             pop, push, pc_err, mispred, orphan;

  bru_state_t       state_q, state_d;
  logic             upd_valid_q, upd_valid_d;
  logic             upd_taken_q, upd_taken_d;
  logic [IDX_W-1:0] upd_index_q, upd_index_d;
  logic             flush_q, flush_d;
  logic [31:0]      redirect_q, redirect_d;
  logic             err_q, err_d;

  assign wr_entry = '{pc: pred_pc, taken: pred_taken, index: pred_index};

  bru_pred_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(bru_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (mispred),
    .push_i  (push),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count)
  );

  // Resolve/enqueue decisions and next values of the registered outputs.
  always_comb begin
    pop     = ex_valid && !fifo_empty;
    orphan  = ex_valid && fifo_empty;
    pc_err  = pop && (head.pc != ex_pc);
    mispred = pop && ((head.taken != ex_taken) || pc_err);
    // Younger predictions are wrong-path on a mispredict, and fetch is being
    // restarted while flush is out, so neither edge accepts an enqueue.
    push    = pred_valid && (!fifo_full || pop) && !mispred && (state_q != ST_FLUSH);

    count_nxt = count + CNT_W'(push) - CNT_W'(pop);

    upd_valid_d = pop;
    upd_taken_d = pop ? ex_taken : NOT_TAKEN;
    upd_index_d = pop ? head.index : '0;
    flush_d     = mispred;
    redirect_d  = mispred ? bru_redirect(ex_taken, ex_pc, ex_target) : '0;
    err_d       = err_q || orphan || pc_err;

    state_d = ST_IDLE;
    if (mispred)                state_d = ST_FLUSH;
    else if (count_nxt != '0)   state_d = ST_TRACK;
  end

  // Output and FSM registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      upd_valid_q <= 1'b0;
      upd_taken_q <= NOT_TAKEN;
      upd_index_q <= '0;
      flush_q     <= 1'b0;
      redirect_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      upd_valid_q <= upd_valid_d;
      upd_taken_q <= upd_taken_d;
      upd_index_q <= upd_index_d;
      flush_q     <= flush_d;
      redirect_q  <= redirect_d;
      err_q       <= err_d;
    end
  end

  assign q_full      = fifo_full;
  assign upd_valid   = upd_valid_q;
  assign upd_taken   = upd_taken_q;
  assign upd_index   = upd_index_q;
  assign flush       = flush_q;
  assign redirect_pc = redirect_q;
  assign err_orphan  = err_q;

`ifdef BRU_STATS_EN
  logic [15:0] stat_br_q, stat_mp_q;

  // Saturating counters, bumped on the edge that launches upd_valid / flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      if (pop && (stat_br_q != '1))     stat_br_q <= stat_br_q + 16'd1;
      if (mispred && (stat_mp_q != '1)) stat_mp_q <= stat_mp_q + 16'd1;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`endif

endmodule
